// File: rtl/seg7_capture.sv
// seg7_capture: recovers per-digit BCD values from a multiplexed,
// active-low 7-segment display bus after a stability qualification.
module seg7_capture #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a,
    input  logic                  b,
    input  logic                  c,
    input  logic                  d,
    input  logic                  e,
    input  logic                  f,
    input  logic                  g,
    input  logic [DIGITS-1:0]     an,
    input  logic                  err_clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     valid,
    output logic                  upd,
    output logic [2:0]            upd_idx,
    output logic                  err
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SAMP_W = DIGITS + 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [SAMP_W-1:0]   samp_q, samp_d;
    logic [SAMP_W-1:0]   prev_q, prev_d;
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic                upd_q, upd_d;
    logic [2:0]          upd_idx_q, upd_idx_d;
    logic                err_q, err_d;

    logic [DIGITS-1:0]   an_low;
    logic [6:0]          seg_s;
    logic                qualified;
    logic                same;
    logic [2:0]          idx;
    logic [3:0]          dec_val;
    logic                dec_digit;
    logic                dec_blank;
    logic [CNT_W-1:0]    cnt_inc;
    logic                capture;

    // Sample qualification, digit index and segment decode of the registered bus
    always_comb begin
        an_low    = ~samp_q[SAMP_W-1:7];
        seg_s     = samp_q[6:0];
        qualified = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
        same      = (samp_q == prev_q);
        idx       = 3'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (an_low[i]) idx = 3'(i);
        end
        dec_val   = 4'hF;
        dec_digit = 1'b1;
        dec_blank = 1'b0;
        case (seg_s)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b1111111: begin
                dec_digit = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_digit = 1'b0;
        endcase
    end

    // Stability FSM; capture fires on the edge where the count reaches STABLE_CYCLES
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        cnt_inc = (cnt_q >= CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (qualified) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_COUNT: begin
                if (!qualified) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (same) begin
                    cnt_d = cnt_inc;
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!qualified) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if ((state_d == ST_COUNT) && (cnt_d >= CNT_W'(STABLE_CYCLES))) begin
            capture = 1'b1;
            state_d = ST_HOLD;
        end
    end

    // Output register updates: digit store, update pulse and sticky error
    always_comb begin
        samp_d    = {an, a, b, c, d, e, f, g};
        prev_d    = samp_q;
        bcd_d     = bcd_q;
        valid_d   = valid_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        err_d     = err_clr ? 1'b0 : err_q;
        if (capture) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (an_low[i]) begin
                    bcd_d[4*i +: 4] = dec_digit ? dec_val : 4'hF;
                    valid_d[i]      = dec_digit;
                end
            end
            upd_d     = 1'b1;
            upd_idx_d = idx;
            if (!dec_digit && !dec_blank) err_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q    <= '0;
            prev_q    <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bcd_q     <= '1;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            samp_q    <= samp_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
        end
    end

    assign bcd     = bcd_q;
    assign valid   = valid_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed testbench for seg7_capture with default parameters.
module tb_seg7_capture;

    logic        clk;
    logic        rst;
    logic        a, b, c, d, e, f, g;
    logic [3:0]  an;
    logic        err_clr;
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        err;

    int errors;
    int checks;

    seg7_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .g       (g),
        .an      (an),
        .err_clr (err_clr),
        .bcd     (bcd),
        .valid   (valid),
        .upd     (upd),
        .upd_idx (upd_idx),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written segment table, a..g with a as the MSB
    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic set_in(input logic [3:0] an_v, input logic [6:0] s);
        an = an_v;
        {a, b, c, d, e, f, g} = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        err_clr = 1'b0;
        set_in(4'b1111, 7'b1111111);
        tick();
        tick();
        checks++; if (bcd !== 16'hFFFF) begin errors++; $display("FAIL reset_bcd got=%h exp=FFFF", bcd); end
        checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=0000", valid); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", upd); end
        checks++; if (upd_idx !== 3'd0) begin errors++; $display("FAIL reset_upd_idx got=%0d exp=0", upd_idx); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
    endtask

    task automatic test_first_capture();
        set_in(4'b1110, 7'b0000110);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (upd !== (k == 5)) begin errors++; $display("FAIL first_upd cycle=%0d got=%b exp=%b", k, upd, (k == 5)); end
            if (k == 5) begin
                checks++;
                if (upd_idx !== 3'd0) begin errors++; $display("FAIL first_upd_idx got=%0d exp=0", upd_idx); end
            end
        end
        checks++; if (bcd !== 16'hFFF3) begin errors++; $display("FAIL first_bcd got=%h exp=FFF3", bcd); end
        checks++; if (valid !== 4'b0001) begin errors++; $display("FAIL first_valid got=%b exp=0001", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL first_err got=%b exp=0", err); end
    endtask

    task automatic test_sweep();
        int n_upd;
        n_upd = 0;
        for (int v = 0; v < 10; v++) begin
            set_in(4'b1011, seg_of(v));
            for (int k = 1; k <= 5; k++) begin
                tick();
                if (upd === 1'b1) n_upd++;
                checks++;
                if (upd !== (k == 5)) begin errors++; $display("FAIL sweep_upd v=%0d cycle=%0d got=%b exp=%b", v, k, upd, (k == 5)); end
            end
            checks++;
            if (bcd[11:8] !== 4'(v)) begin errors++; $display("FAIL sweep_bcd got=%h exp=%h", bcd[11:8], 4'(v)); end
            checks++;
            if (valid[2] !== 1'b1) begin errors++; $display("FAIL sweep_valid got=%b exp=1", valid[2]); end
        end
        checks++; if (n_upd != 10) begin errors++; $display("FAIL sweep_count got=%0d exp=10", n_upd); end
        set_in(4'b1011, seg_of(5));
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (upd !== 1'b0) begin errors++; $display("FAIL short_hold_upd cycle=%0d got=%b exp=0", k, upd); end
        end
        checks++; if (bcd !== 16'hF9F3) begin errors++; $display("FAIL short_hold_bcd got=%h exp=F9F3", bcd); end
    endtask

    task automatic test_contention();
        set_in(4'b1100, 7'b0000000);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (upd !== 1'b0) begin errors++; $display("FAIL contention_upd cycle=%0d got=%b exp=0", k, upd); end
        end
        checks++; if (bcd !== 16'hF9F3) begin errors++; $display("FAIL contention_bcd got=%h exp=F9F3", bcd); end
        checks++; if (valid !== 4'b0101) begin errors++; $display("FAIL contention_valid got=%b exp=0101", valid); end
        set_in(4'b0111, 7'b0000000);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (upd !== (k == 5)) begin errors++; $display("FAIL digit3_upd cycle=%0d got=%b exp=%b", k, upd, (k == 5)); end
        end
        checks++; if (upd_idx !== 3'd3) begin errors++; $display("FAIL digit3_upd_idx got=%0d exp=3", upd_idx); end
        checks++; if (bcd !== 16'h89F3) begin errors++; $display("FAIL digit3_bcd got=%h exp=89F3", bcd); end
        checks++; if (valid !== 4'b1101) begin errors++; $display("FAIL digit3_valid got=%b exp=1101", valid); end
    endtask

    task automatic test_invalid_err();
        set_in(4'b1101, 7'b1111110);
        for (int k = 1; k <= 5; k++) tick();
        checks++; if (upd !== 1'b1 || upd_idx !== 3'd1) begin errors++; $display("FAIL invalid_upd got=%b/%0d exp=1/1", upd, upd_idx); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_err got=%b exp=1", err); end
        checks++; if (bcd !== 16'h89F3) begin errors++; $display("FAIL invalid_bcd got=%h exp=89F3", bcd); end
        checks++; if (valid !== 4'b1101) begin errors++; $display("FAIL invalid_valid got=%b exp=1101", valid); end
        // Second invalid capture coinciding with err_clr: set wins
        set_in(4'b1101, 7'b1111100);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
        end
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL second_invalid_upd got=%b exp=1", upd); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL set_wins_err got=%b exp=1", err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr got=%b exp=0", err); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_stays_clear got=%b exp=0", err); end
    endtask

    task automatic test_flicker();
        for (int p = 0; p < 10; p++) begin
            set_in(4'b1110, (p % 2 == 0) ? 7'b1001111 : 7'b0000001);
            for (int k = 1; k <= 2; k++) begin
                tick();
                checks++;
                if (upd !== 1'b0) begin errors++; $display("FAIL flicker_upd phase=%0d got=%b exp=0", p, upd); end
            end
        end
        set_in(4'b1110, 7'b1001111);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (upd !== (k == 5)) begin errors++; $display("FAIL settle_upd cycle=%0d got=%b exp=%b", k, upd, (k == 5)); end
        end
        checks++; if (bcd !== 16'h89F1) begin errors++; $display("FAIL settle_bcd got=%h exp=89F1", bcd); end
    endtask

    task automatic test_reset_mid_count();
        set_in(4'b1110, 7'b0000100);
        for (int k = 1; k <= 3; k++) tick();
        rst = 1'b1;
        tick();
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL midrst_upd got=%b exp=0", upd); end
        checks++; if (bcd !== 16'hFFFF) begin errors++; $display("FAIL midrst_bcd got=%h exp=FFFF", bcd); end
        checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL midrst_valid got=%b exp=0000", valid); end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (upd !== (k == 5)) begin errors++; $display("FAIL postrst_upd cycle=%0d got=%b exp=%b", k, upd, (k == 5)); end
        end
        checks++; if (bcd !== 16'hFFF9) begin errors++; $display("FAIL postrst_bcd got=%h exp=FFF9", bcd); end
        checks++; if (valid !== 4'b0001) begin errors++; $display("FAIL postrst_valid got=%b exp=0001", valid); end
        checks++; if (upd_idx !== 3'd0) begin errors++; $display("FAIL postrst_upd_idx got=%0d exp=0", upd_idx); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        err_clr = 1'b0;
        set_in(4'b1111, 7'b1111111);
        test_reset();
        test_first_capture();
        test_sweep();
        test_contention();
        test_invalid_err();
        test_flicker();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Reads a time-multiplexed, active-low 7-segment display bus: segment lines a..g plus per-digit anode enables.
- Recovers the BCD value of each digit, acting as the receiving end of the BCD-to-7-segment path.
- Used on the bench and in loopback designs to check what a display driver actually shows.
- Samples the bus, requires a stable pattern before accepting it, and holds one BCD register per digit.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical samples required before capture (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
a,b,c,d,e,f,g  input  1 each  segment lines, active-low (0 = lit)
an  input  DIGITS  digit enables, active-low; bit i selects digit i
err_clr  input  1  clears err when high
bcd  output  4*DIGITS  captured digits; digit i at bits [4i+3:4i]
valid  output  DIGITS  bit i = digit i holds a decoded 0..9 value
upd  output  1  one-cycle pulse on each capture
upd_idx  output  3  index of the digit captured with upd
err  output  1  sticky flag: an undecodable pattern was captured

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-high.
- Reset values: bcd all 4'hF, valid 0, upd 0, upd_idx 0, err 0, sample history and stability counter cleared, FSM in IDLE.
- Input register: {an, a..g} is registered on every edge. All decisions use registered samples.
- Decode table, {a..g} -> value:
  - 0000001 -> 0; 1001111 -> 1; 0010010 -> 2; 0000110 -> 3; 1001100 -> 4
  - 0100100 -> 5; 0100000 -> 6; 0001111 -> 7; 0000000 -> 8; 0000100 -> 9
  - 1111111 -> blank
  - any other pattern -> invalid
- Qualified sample: an has exactly one bit low.
  - All bits high (no digit) or two or more bits low (contention) is unqualified.
- FSM states:
  - IDLE -> COUNT when the sample is qualified; counter loads 1.
  - COUNT: a sample identical to the previous sample increments the counter.
    - Counter reaches STABLE_CYCLES -> capture on the next edge, go to HOLD.
    - A differing qualified sample reloads 1 and stays in COUNT.
    - An unqualified sample goes to IDLE.
  - HOLD: no further capture while the sample is unchanged.
    - A differing qualified sample -> COUNT, counter loads 1.
    - An unqualified sample -> IDLE.
- Latency: {an, segs} valid and held before edge 1 -> capture at edge STABLE_CYCLES+1.
  - bcd, valid and upd are visible after that edge.
  - upd drops after edge STABLE_CYCLES+2.
  - With the defaults, upd is high between edges 5 and 6.
- Capture actions for digit i (index of the low an bit):
  - Digit 0..9: bcd[i] gets the value, valid[i] is set.
  - Blank: bcd[i] gets 4'hF, valid[i] is cleared, err unchanged.
  - Invalid: bcd[i] gets 4'hF, valid[i] is cleared, err is set.
  - Every capture pulses upd for one cycle with upd_idx = i.
  - Digits other than i are untouched.
- Re-capture: an identical pattern returning after any other sample starts a new stability count and captures again (upd pulses again).
- err_clr: clears err on the next edge. If a new invalid capture happens on the same edge, set wins (err stays 1).
- Reset asserted mid-count or mid-HOLD: everything returns to reset values on that edge, and no capture completes.
  - After rst deasserts, a full STABLE_CYCLES count is required again.
- Width rule: counter width is clog2(STABLE_CYCLES+1). The counter saturates and never wraps.
- DIGITS < 8: upd_idx upper bits are 0.

Test Plan:
1. Reset, then an=4'b1110 with segs 0000110 held 6 cycles -> upd pulse at edge 5, upd_idx=0, bcd[3:0]=3, valid=4'b0001, err=0.
2. Sweep 0..9 on digit 2 (an=4'b1011), each held 5 cycles -> bcd[11:8] matches each value, 10 upd pulses, valid[2]=1; a 3-cycle hold produces no upd.
3. an=4'b1100 (two digits low) with segs 0000000 held 10 cycles -> no upd, bcd/valid unchanged; then an=4'b0111 held 5 cycles -> bcd[15:12]=8, upd_idx=3.
4. Segs 1111110 on digit 1 for 5 cycles -> err=1, bcd[7:4]=F, valid[1]=0. Then err_clr high on the same edge as a second invalid capture -> err stays 1; err_clr alone -> err=0.
5. Digit 0 pattern flips every 2 cycles for 20 cycles -> no upd. Then hold 1001111 -> single upd, bcd[3:0]=1.
6. rst asserted after 3 stable samples of 9 on digit 0 -> no capture, outputs at reset values; after release a further 4 stable samples are needed for capture.
